// File: rtl/gate_stim_seq.sv
// Purpose : exhaustive/structured 4-bit stimulus generator for a downstream gate block.
// Latency : vector 0 appears one cycle after an accepted start; each vector is held max(dwell,1) cycles.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while RUN/FIN.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-high reset
//   start, abort      : run request (IDLE only) and synchronous stop of a running sequence
//   mode, dwell       : pattern select and per-vector hold time, latched when start is accepted
//   a, b, c, d        : registered stimulus bits, {a,b,c,d} = pattern[3:0]
//   vec_valid, vec_idx: vector qualifier and index of the vector currently driven
//   busy, done        : high for the whole sequence / one-cycle pulse after normal completion
module gate_stim_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               vec_valid,
    output logic [3:0]         vec_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Pattern for a given mode and vector index.
    //   0: binary count, 1: Gray code, 2: walking one from the MSB, 3: 0000/1111 alternation
    function automatic logic [3:0] pattern(input logic [1:0] m, input logic [3:0] i);
        logic [3:0] p;
        case (m)
            2'd0:    p = i;
            2'd1:    p = i ^ (i >> 1);
            2'd2:    p = 4'b1000 >> i[1:0];
            default: p = {4{i[0]}};
        endcase
        return p;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         pat_q, pat_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One bit wider than the counter so the compare cannot overflow when
    // dwell is all-ones. Comparing cnt+1 >= dwell makes dwell=0 expire on
    // the first cycle, i.e. it behaves exactly like dwell=1.
    logic [DWELL_W:0]   cnt_inc;
    logic               dwell_exp;
    logic [3:0]         last_idx;

    assign cnt_inc   = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    assign dwell_exp = (cnt_inc >= {1'b0, dwell_q});
    // Modes 2 and 3 are four vectors long, modes 0 and 1 sixteen.
    assign last_idx  = mode_q[1] ? 4'd3 : 4'd15;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        // Output registers default to their idle values; only RUN drives them.
        pat_d   = 4'h0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has priority over a simultaneous start.
                if (start && !abort) begin
                    state_d = RUN;
                    mode_d  = mode;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    pat_d   = pattern(mode, 4'd0);
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    mode_d  = 2'd0;
                    dwell_d = '0;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                end else if (dwell_exp) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        // Last dwell cycle of the last vector: no wrap, go report.
                        state_d = FIN;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        pat_d  = pattern(mode_q, idx_q + 4'd1);
                        vld_d  = 1'b1;
                        busy_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_inc[DWELL_W-1:0];
                    pat_d  = pat_q;
                    vld_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end

            FIN: begin
                // Unconditional exit: done has already been registered for
                // this cycle, so abort or start here changes nothing.
                state_d = IDLE;
                mode_d  = 2'd0;
                dwell_d = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            pat_q   <= 4'h0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // All outputs come straight from flops.
    assign a         = pat_q[3];
    assign b         = pat_q[2];
    assign c         = pat_q[1];
    assign d         = pat_q[0];
    assign vec_valid = vld_q;
    assign vec_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Purpose : directed self-checking bench for gate_stim_seq.
// Latency : checks sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; stimulus is a linear sequence of directed steps.
module tb_gate_stim_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic       a, b, c, d;
    logic       vec_valid;
    logic [3:0] vec_idx;
    logic       busy;
    logic       done;
    logic [3:0] abcd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] walk [4] = '{4'h8, 4'h4, 4'h2, 4'h1};

    gate_stim_seq #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .dwell     (dwell),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .vec_valid (vec_valid),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign abcd = {a, b, c, d};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int p, input int v,
                             input int i, input int bs, input int dn);
        check({tag, ".abcd"},      int'(abcd),      p);
        check({tag, ".vec_valid"}, int'(vec_valid), v);
        check({tag, ".vec_idx"},   int'(vec_idx),   i);
        check({tag, ".busy"},      int'(busy),      bs);
        check({tag, ".done"},      int'(done),      dn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int e;
        logic [3:0] prev;

        // Reset with start already held high and a sequence configured.
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        mode  = 2'd0;
        dwell = 8'd2;
        prev  = 4'h0;
        #12;
        check_out("rst_hold", 0, 0, 0, 0, 0);
        #10;
        rst = 1'b0;
        #1;
        check_out("rst_release", 0, 0, 0, 0, 0);

        // Mode 0, dwell 2: first edge after release accepts the start.
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 3) begin
                mode  = 2'd3;
                dwell = 8'd0;
            end
            check_out($sformatf("m0_k%0d", k), k / 2, 1, k / 2, 1, 0);
            tick();
        end
        check_out("m0_fin", 0, 0, 0, 0, 1);
        tick();
        check_out("m0_idle", 0, 0, 0, 0, 0);

        // Mode 1, dwell 1: Gray code, one bit changes per vector.
        mode  = 2'd1;
        dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            g = i ^ (i >> 1);
            check_out($sformatf("m1_i%0d", i), g, 1, i, 1, 0);
            if (i > 0)
                check($sformatf("m1_onebit_i%0d", i), $countones(prev ^ abcd), 1);
            prev = abcd;
            tick();
        end
        check_out("m1_fin", 0, 0, 0, 0, 1);
        tick();
        check_out("m1_idle", 0, 0, 0, 0, 0);

        // Mode 2, dwell 0: behaves as dwell 1.
        mode  = 2'd2;
        dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("m2_i%0d", i), int'(walk[i]), 1, i, 1, 0);
            tick();
        end
        check_out("m2_fin", 0, 0, 0, 0, 1);
        tick();
        check_out("m2_idle", 0, 0, 0, 0, 0);

        // Mode 3, dwell 3, abort on the 5th RUN cycle.
        mode  = 2'd3;
        dwell = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("m3_k%0d", k), ((k / 3) % 2 == 1) ? 15 : 0, 1, k / 3, 1, 0);
            if (k == 4)
                abort = 1'b1;
            tick();
        end
        check_out("m3_abort", 0, 0, 0, 0, 0);
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("m3_post_k%0d", k), 0, 0, 0, 0, 0);
        end

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        check_out("start_abort_idle", 0, 0, 0, 0, 0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check_out("start_abort_idle2", 0, 0, 0, 0, 0);

        // Abort during FIN does not cut the done pulse.
        mode  = 2'd3;
        dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_out($sformatf("finab_k%0d", k), (k % 2 == 1) ? 15 : 0, 1, k, 1, 0);
            tick();
        end
        abort = 1'b1;
        check_out("finab_fin", 0, 0, 0, 0, 1);
        tick();
        abort = 1'b0;
        check_out("finab_idle", 0, 0, 0, 0, 0);
        tick();
        check_out("finab_idle2", 0, 0, 0, 0, 0);

        // start held high for 40 cycles, mode 2, dwell 4: back-to-back runs
        // separated only by FIN and the IDLE cycle that samples start.
        mode  = 2'd2;
        dwell = 8'd4;
        start = 1'b1;
        e     = 0;
        tick();
        e++;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                check_out($sformatf("hold_r%0d_k%0d", r, k), int'(walk[k / 4]), 1, k / 4, 1, 0);
                tick();
                e++;
                if (e == 40) start = 1'b0;
            end
            check_out($sformatf("hold_r%0d_fin", r), 0, 0, 0, 0, 1);
            tick();
            e++;
            if (e == 40) start = 1'b0;
            check_out($sformatf("hold_r%0d_idle", r), 0, 0, 0, 0, 0);
            tick();
            e++;
            if (e == 40) start = 1'b0;
        end
        check_out("hold_no_4th_run", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-RUN in mode 0, then a fresh start.
        mode  = 2'd0;
        dwell = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("rstmid_k%0d", k), k / 2, 1, k / 2, 1, 0);
            tick();
        end
        check_out("rstmid_before", 2, 1, 2, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        check_out("rstmid_async", 0, 0, 0, 0, 0);
        tick();
        check_out("rstmid_held", 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        tick();
        check_out("rstmid_wait", 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("restart_k0", 0, 1, 0, 1, 0);
        tick();
        check_out("restart_k1", 0, 1, 0, 1, 0);
        tick();
        check_out("restart_k2", 1, 1, 1, 1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("restart_abort", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
